i2c_slave_mem: RTL and testbench

I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

---
 rtl/i2c_slave_mem.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// I2C slave exposing a 256x8 memory with an auto-incrementing word pointer.
// SCL/SDA are synchronised and glitch-filtered; the slave never drives SCL.
module i2c_slave_mem #(
    parameter logic [6:0]  G_SLAVE_ADDR = 7'h50,
    parameter int unsigned G_FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sclk,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_val,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

    localparam int unsigned CntW = $clog2(G_FILTER_LEN + 1);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StWptr,
        StAckWptr,
        StWdata,
        StAckWdata,
        StRdata,
        StRack,
        StWaitStop
    } state_e;

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
    logic [CntW-1:0] filt_cnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) filt_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {i_sclk, i_sda};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            // A new level is accepted only after G_FILTER_LEN identical samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    filt_cnt_q[i] <= '0;
                end else if (filt_cnt_q[i] == CntW'(G_FILTER_LEN - 1)) begin
                    filt_q[i]     <= sync2_q[i];
                    filt_cnt_q[i] <= '0;
                end else begin
                    filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    assign scl       = filt_q[1];
    assign sda       = filt_q[0];
    assign scl_rise  = scl & ~prev_q[1];
    assign scl_fall  = ~scl & prev_q[1];
    assign start_det = scl & prev_q[0] & ~sda;
    assign stop_det  = scl & ~prev_q[0] & sda;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       wr_val_q, wr_val_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] mem [256];
    logic [7:0] rd_byte, rx_byte;
    logic       mem_we, load_rd;

    assign rd_byte = mem[ptr_q];
    assign rx_byte = {shreg_q[6:0], sda};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_val_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        load_rd   = 1'b0;

        if (stop_det) begin
            state_d   = StIdle;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = StAddr;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StAddr, StWptr, StWdata: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == StWdata && bit_cnt_q == 4'd7) begin
                            mem_we    = 1'b1;
                            wr_val_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_q + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            if (shreg_q[7:1] == G_SLAVE_ADDR) begin
                                rw_d    = shreg_q[0];
                                busy_d  = 1'b1;
                                oe_d    = 1'b1;
                                state_d = StAckAddr;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = StWaitStop;
                            end
                        end else begin
                            if (state_q == StWptr) ptr_d = shreg_q;
                            oe_d    = 1'b1;
                            state_d = (state_q == StWptr) ? StAckWptr : StAckWdata;
                        end
                    end
                end
                StAckAddr, StAckWptr, StAckWdata: begin
                    if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == StAckAddr && rw_q) begin
                            load_rd = 1'b1;
                        end else if (state_q == StAckAddr) begin
                            state_d = StWptr;
                        end else begin
                            state_d = StWdata;
                        end
                    end
                end
                StRdata: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StRack;
                        end else begin
                            oe_d      = ~shreg_q[6];
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRack: begin
                    if (scl_rise) begin
                        if (sda) begin
                            busy_d  = 1'b0;
                            state_d = StWaitStop;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        load_rd = 1'b1;
                    end
                end
                default: ;
            endcase

            if (load_rd) begin
                shreg_d   = rd_byte;
                ptr_d     = ptr_q + 8'd1;
                oe_d      = ~rd_byte[7];
                bit_cnt_d = 4'd1;
                state_d   = StRdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_val_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_val_q  <= wr_val_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr_q] <= rx_byte;
    end

    assign o_sda_oe  = oe_q;
    assign o_wr_val  = wr_val_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, write/read scoreboards.
module tb_i2c_slave_mem;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       o_sda_oe, o_wr_val, o_busy;
    logic [7:0] o_wr_addr, o_wr_data;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    assign sda_line = sda_m & ~o_sda_oe;

    i2c_slave_mem #(
        .G_SLAVE_ADDR(7'h50),
        .G_FILTER_LEN(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_sclk   (scl_m),
        .i_sda    (sda_line),
        .o_sda_oe (o_sda_oe),
        .o_wr_val (o_wr_val),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_sda_oe) oe_cnt++;
        if (o_wr_val) begin
            check_eq("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) check_eq("wr_addr_data", {o_wr_addr, o_wr_data}, exp_wr.pop_front());
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            wait_q(); sda_m = 1'b1;
            wait_q(); scl_m = 1'b1;
            wait_q();
        end
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q(); wait_q();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        wait_q(); sda_m = b;
        wait_q(); scl_m = 1'b1;
        wait_q();
        if (glitch) begin
            sda_m = ~b;
            @(negedge clk);
            sda_m = b;
        end
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); ack = sda_line;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input string tag);
        logic ack;
        send_byte(b, -1, ack);
        check_eq(tag, 32'(ack), 32'd0);
    endtask

    task automatic read_byte(input logic [7:0] expv, input logic nack);
        logic [7:0] got;
        exp_rd.push_back(expv);
        for (int i = 7; i >= 0; i--) begin
            wait_q(); sda_m = 1'b1;
            wait_q(); scl_m = 1'b1;
            wait_q(); got[i] = sda_line;
            wait_q(); scl_m = 1'b0;
        end
        wait_q(); sda_m = nack;
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q(); scl_m = 1'b0;
        check_eq("rd_byte", 32'(got), 32'(exp_rd.pop_front()));
    endtask

    initial begin
        logic ack;
        int   oe_snap;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_oe", 32'(o_sda_oe), 32'd0);
        check_eq("rst_wr_val", 32'(o_wr_val), 32'd0);
        check_eq("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(o_wr_data), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        wait_q();

        // Plain write of two bytes starting at 0x10.
        i2c_start();
        put_byte(8'hA0, "wr_addr_ack");
        check_eq("busy_after_ack", 32'(o_busy), 32'd1);
        put_byte(8'h10, "wptr_ack");
        exp_wr.push_back(16'h105A);
        put_byte(8'h5A, "wdata0_ack");
        exp_wr.push_back(16'h11C3);
        put_byte(8'hC3, "wdata1_ack");
        i2c_stop();
        check_eq("busy_after_stop", 32'(o_busy), 32'd0);
        check_eq("wr_drained_1", 32'(exp_wr.size()), 32'd0);

        // Pointer set, repeated START, read two bytes with ACK then NACK.
        i2c_start();
        put_byte(8'hA0, "rd_wr_addr_ack");
        put_byte(8'h10, "rd_wptr_ack");
        i2c_start();
        put_byte(8'hA1, "rd_addr_ack");
        read_byte(8'h5A, 1'b0);
        read_byte(8'hC3, 1'b1);
        i2c_stop();
        check_eq("busy_after_read", 32'(o_busy), 32'd0);

        // Foreign address: never acknowledged, SDA never pulled.
        oe_snap = oe_cnt;
        i2c_start();
        send_byte(8'hA4, -1, ack);
        check_eq("mismatch_nack", 32'(ack), 32'd1);
        send_byte(8'h33, -1, ack);
        check_eq("mismatch_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        check_eq("mismatch_no_oe", 32'(oe_cnt - oe_snap), 32'd0);
        check_eq("mismatch_busy", 32'(o_busy), 32'd0);

        // Pointer wrap on write and on read.
        i2c_start();
        put_byte(8'hA0, "wrap_addr_ack");
        put_byte(8'hFF, "wrap_wptr_ack");
        exp_wr.push_back(16'hFF11);
        put_byte(8'h11, "wrap_d0_ack");
        exp_wr.push_back(16'h0022);
        put_byte(8'h22, "wrap_d1_ack");
        i2c_stop();
        check_eq("wr_drained_wrap", 32'(exp_wr.size()), 32'd0);
        i2c_start();
        put_byte(8'hA0, "wrap_rd_waddr_ack");
        put_byte(8'hFF, "wrap_rd_wptr_ack");
        i2c_start();
        put_byte(8'hA1, "wrap_rd_addr_ack");
        read_byte(8'h11, 1'b0);
        read_byte(8'h22, 1'b1);
        i2c_stop();

        // One-sample SDA glitches while SCL is high must not look like START/STOP.
        i2c_start();
        put_byte(8'hA0, "glitch_addr_ack");
        put_byte(8'h40, "glitch_wptr_ack");
        exp_wr.push_back(16'h40C3);
        send_byte(8'hC3, 7, ack);
        check_eq("glitch_start_ack", 32'(ack), 32'd0);
        exp_wr.push_back(16'h415A);
        send_byte(8'h5A, 5, ack);
        check_eq("glitch_stop_ack", 32'(ack), 32'd0);
        i2c_stop();
        check_eq("wr_drained_glitch", 32'(exp_wr.size()), 32'd0);

        // Reset in the middle of a data byte abandons the write.
        i2c_start();
        put_byte(8'hA0, "rst_addr_ack");
        put_byte(8'h60, "rst_wptr_ack");
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_oe", 32'(o_sda_oe), 32'd0);
        check_eq("midrst_busy", 32'(o_busy), 32'd0);
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q();
        i2c_start();
        put_byte(8'hA0, "post_rst_addr_ack");
        put_byte(8'h60, "post_rst_wptr_ack");
        exp_wr.push_back(16'h609C);
        put_byte(8'h9C, "post_rst_data_ack");
        i2c_stop();
        check_eq("wr_drained_rst", 32'(exp_wr.size()), 32'd0);
        i2c_start();
        put_byte(8'hA0, "post_rst_rd_waddr_ack");
        put_byte(8'h10, "post_rst_rd_wptr_ack");
        i2c_start();
        put_byte(8'hA1, "post_rst_rd_addr_ack");
        read_byte(8'h5A, 1'b1);
        i2c_stop();

        wait_q();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
